// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch stage feeding the control unit. Holds a
//               small program memory, a program counter and a hold counter,
//               keeps each instruction stable for as many cycles as the
//               control unit spends on its class, and halts on a class-00
//               word.
//               Optional: define IFU_INSTR_COUNT_EN to add a saturating
//               16-bit count of issued instructions (instr_count).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int INSTR_WIDTH  = 20,
    parameter int PC_BITS      = 5,
    parameter int STD_CYCLES   = 3,
    parameter int LOAD_CYCLES  = 4,
    parameter int STORE_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   prog_we,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_BITS-1:0]     pc,
    output logic                   issue,
    output logic                   busy,
    output logic                   halted,
    output logic                   prog_err
`ifdef IFU_INSTR_COUNT_EN
    ,
    output logic [15:0]            instr_count
`endif
);

    localparam int C_DEPTH = 1 << PC_BITS;
    localparam int C_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [C_CNT_W-1:0]      r_cnt;
    logic [C_CNT_W-1:0]      w_cnt_nxt;
    logic [INSTR_WIDTH-1:0]  w_instr_nxt;
    logic [PC_BITS-1:0]      w_pc_nxt;
    logic                    w_issue_nxt;
    logic                    w_prog_err_nxt;
    logic [INSTR_WIDTH-1:0]  r_mem [C_DEPTH];
    logic [INSTR_WIDTH-1:0]  w_fetch;
    logic [1:0]              w_cls;

    // Hold length of an instruction class; class 00 never issues.
    function automatic logic [C_CNT_W-1:0] len_of(input logic [1:0] cls);
        case (cls)
            2'b01:   len_of = C_CNT_W'(STD_CYCLES);
            2'b10:   len_of = C_CNT_W'(LOAD_CYCLES);
            2'b11:   len_of = C_CNT_W'(STORE_CYCLES);
            default: len_of = '0;
        endcase
    endfunction

    assign w_fetch = r_mem[pc];
    assign w_cls   = w_fetch[INSTR_WIDTH-1 -: 2];

    // Program memory write port; writes are locked out while issuing.
    always_ff @(posedge clk) begin
        if (prog_we && (r_state != ISSUE)) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // Next-state and next-output logic for the fetch sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_instr_nxt    = instr;
        w_pc_nxt       = pc;
        w_cnt_nxt      = r_cnt;
        w_issue_nxt    = 1'b0;
        w_prog_err_nxt = prog_we && (r_state == ISSUE);
        case (r_state)
            IDLE: begin
                w_instr_nxt = '0;
                if (start) begin
                    if (w_cls != 2'b00) begin
                        // Extra priming cycle while the control unit leaves RESET.
                        w_instr_nxt = w_fetch;
                        w_pc_nxt    = pc + PC_BITS'(1);
                        w_cnt_nxt   = len_of(w_cls) + C_CNT_W'(1);
                        w_issue_nxt = 1'b1;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_state_nxt = HALT;
                    end
                end
            end
            ISSUE: begin
                if (r_cnt <= C_CNT_W'(1)) begin
                    if (w_cls != 2'b00) begin
                        w_instr_nxt = w_fetch;
                        w_pc_nxt    = pc + PC_BITS'(1);
                        w_cnt_nxt   = len_of(w_cls);
                        w_issue_nxt = 1'b1;
                    end else begin
                        w_instr_nxt = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = HALT;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - C_CNT_W'(1);
                end
            end
            HALT: begin
                w_instr_nxt = '0;
            end
            default: begin
                w_instr_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset takes effect immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            instr    <= '0;
            pc       <= '0;
            issue    <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            prog_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            instr    <= w_instr_nxt;
            pc       <= w_pc_nxt;
            issue    <= w_issue_nxt;
            busy     <= (w_state_nxt == ISSUE);
            halted   <= (w_state_nxt == HALT);
            prog_err <= w_prog_err_nxt;
        end
    end

`ifdef IFU_INSTR_COUNT_EN
    // Saturating count of issued instructions, in step with the issue pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_count <= '0;
        end else if (w_issue_nxt && (instr_count != 16'hFFFF)) begin
            instr_count <= instr_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [19:0] prog_data;
    logic [19:0] instr;
    logic [4:0]  pc;
    logic        issue;
    logic        busy;
    logic        halted;
    logic        prog_err;
`ifdef IFU_INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .instr     (instr),
        .pc        (pc),
        .issue     (issue),
        .busy      (busy),
        .halted    (halted),
        .prog_err  (prog_err)
`ifdef IFU_INSTR_COUNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_mem(input logic [4:0] a, input logic [19:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [19:0] exp_i;
        logic [19:0] last_i;
        int          n_iss;
        logic        exp_iss;

        rst = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        @(negedge clk);
        check("rst_instr", instr, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_issue", issue, 0);
        check("rst_prog_err", prog_err, 0);
        @(negedge clk);
        rst = 1'b1;

        // Scenario 1: std, load, halt.
        write_mem(5'd0, 20'h56123);
        write_mem(5'd1, 20'h94051);
        write_mem(5'd2, 20'h00000);
        pulse_start();
        n_iss = 0;
        for (int k = 0; k < 10; k++) begin
            exp_i = (k < 4) ? 20'h56123 : (k < 8) ? 20'h94051 : 20'h0;
            check("s1_instr", instr, exp_i);
            check("s1_busy", busy, (k < 8) ? 1 : 0);
            if (issue) n_iss++;
            @(negedge clk);
        end
        check("s1_halted", halted, 1);
        check("s1_pc", pc, 2);
        check("s1_issues", n_iss, 2);
        pulse_start();
        check("s1_halt_start_halted", halted, 1);
        check("s1_halt_start_pc", pc, 2);
        check("s1_halt_start_instr", instr, 0);
`ifdef IFU_INSTR_COUNT_EN
        check("s1_count", instr_count, 2);
`endif
        do_reset();
`ifdef IFU_INSTR_COUNT_EN
        check("s1_count_rst", instr_count, 0);
`endif
        check("s1_rst_halted", halted, 0);

        // Scenario 2: store (3 + priming), std, halt.
        write_mem(5'd0, 20'hD4012);
        write_mem(5'd1, 20'h50001);
        pulse_start();
        for (int k = 0; k < 9; k++) begin
            exp_i = (k < 4) ? 20'hD4012 : (k < 7) ? 20'h50001 : 20'h0;
            check("s2_instr", instr, exp_i);
            @(negedge clk);
        end
        check("s2_halted", halted, 1);
        check("s2_pc", pc, 2);

        // Scenario 3: write during ISSUE is rejected; write with start in IDLE.
        do_reset();
        for (int a = 0; a < 5; a++) write_mem(5'(a), 20'h50000 + 20'(a));
        write_mem(5'd5, 20'h50055);
        write_mem(5'd6, 20'h00000);
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = 20'h0; start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        check("s3_prewrite_fetch", instr, 20'h50000);
        check("s3_idle_write_err", prog_err, 0);
        prog_we = 1'b1; prog_addr = 5'd5; prog_data = 20'hFFFFF;
        @(negedge clk);
        prog_we = 1'b0;
        check("s3_prog_err", prog_err, 1);
        @(negedge clk);
        check("s3_prog_err_pulse", prog_err, 0);
        n_iss = 0;
        last_i = '0;
        for (int i = 0; i < 60 && !halted; i++) begin
            if (issue) begin
                last_i = instr;
                n_iss++;
            end
            @(negedge clk);
        end
        check("s3_halted", halted, 1);
        check("s3_mem5", last_i, 20'h50055);
        check("s3_issues", n_iss, 5);
        check("s3_pc", pc, 6);
        do_reset();
        pulse_start();
        check("s3_mem0_halted", halted, 1);
        check("s3_mem0_pc", pc, 0);
        check("s3_mem0_instr", instr, 0);

        // Scenario 4: full memory, pc wraps with no gap.
        do_reset();
        for (int a = 0; a < 32; a++) write_mem(5'(a), 20'h50000);
        pulse_start();
        for (int k = 0; k < 100; k++) begin
            exp_iss = (k == 0) || (k >= 4 && ((k - 4) % 3) == 0);
            check("s4_issue", issue, exp_iss);
            check("s4_busy", busy, 1);
            if (k == 94) check("s4_wrap_pc", pc, 0);
            if (k == 97) check("s4_after_wrap_pc", pc, 1);
            @(negedge clk);
        end

        // Scenario 5: asynchronous reset between edges.
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("s5_async_instr", instr, 0);
        check("s5_async_pc", pc, 0);
        check("s5_async_busy", busy, 0);
        check("s5_async_issue", issue, 0);
        @(negedge clk);
        rst = 1'b1;
        pulse_start();
        check("s5_rerun_instr", instr, 20'h50000);
        check("s5_rerun_pc", pc, 1);
        check("s5_rerun_issue", issue, 1);
        check("s5_rerun_busy", busy, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
